rtc_bus_responder: RTL and testbench
====================================

RTC_BUS_RESPONDER -- requirements
Module: rtc_bus_responder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000, clk cycles per 1 Hz timekeeping tick (min 4).
REQ-002 SHALL have ports: clk  input  1  system clock, single clock domain.
REQ-003 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have: AD  input  1  active-low; 0 = address phase, 1 = data phase.
REQ-005 SHALL have: CS  input  1  active-low chip select.
REQ-006 SHALL have: RD  input  1  active-low read strobe.
REQ-007 SHALL have: WR  input  1  active-low write strobe.
REQ-008 SHALL have: bus  inout  8  multiplexed address/data; driven only during reads.
REQ-009 SHALL have: IRQ  output  1  active-low interrupt request.

Function
REQ-010 SHALL pass AD, CS, RD and WR through 2-flop synchronizers, and capture bus into a register every cycle while the synchronized WR is 0.
REQ-011 SHALL latch the captured byte into the 8-bit address register when synchronized WR rises with CS=0 and AD=0.
REQ-012 SHALL write the captured byte to the register addressed when synchronized WR rises with CS=0 and AD=1.
REQ-013 SHALL drive bus from the addressed register while synchronized CS=0, RD=0 and AD=1, and release bus to Z one cycle after that condition ends.
REQ-014 Latency: bus driven no later than 3 clk after RD falls; the initiator holds RD low at least 4 clk and WR low at least 3 clk.
REQ-015 Register map: 0x21 seconds (BCD 00-59), 0x22 minutes (BCD 00-59), 0x23 hours (BCD 00-23), 0x41 timer (binary countdown), 0x0F control (bit1 IE, bit0 TF, bits 7:2 read 0).
REQ-016 Unmapped addresses SHALL read 0x00, and writes to them SHALL be ignored.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap.
REQ-018 On each tick, seconds SHALL increment as follows: value >= 0x59 -> 0x00 with carry; low nibble >= 9 -> high nibble +1, low nibble 0; otherwise +1.
REQ-019 Minutes SHALL follow the same rule on seconds carry; hours SHALL do so on minutes carry, wrapping at 0x23 -> 0x00 with no further carry.
REQ-020 A bus write to seconds SHALL clear the prescaler.
REQ-021 A bus write to a time register in the same cycle as its increment SHALL win, and the carry out of that register SHALL be suppressed that cycle.
REQ-022 Invalid BCD values SHALL be stored as written and then increment per REQ-018.
REQ-023 A read SHALL return the register value registered at the cycle the drive starts; no snapshot latching is applied.

Reset
REQ-024 rst SHALL asynchronously clear: synchronizers to 1 (idle), address 0x00, seconds/minutes/hours 0x00, timer 0x00, IE 0, TF 0, prescaler 0, bus drive off (Z), IRQ 1.
REQ-025 Reset during any bus phase SHALL abort it, with no register write and bus released immediately.

Configuration
REQ-026 Macro RTC_TIMER_IRQ_EN SHALL control the timer and interrupt feature.
REQ-027 With RTC_TIMER_IRQ_EN defined: on tick, a nonzero timer SHALL decrement; a 1 -> 0 transition SHALL set TF; IRQ = ~(TF & IE).
REQ-028 With RTC_TIMER_IRQ_EN defined: writing 0 to TF SHALL clear it and writing 1 SHALL have no effect; simultaneous set and clear SHALL leave TF = 1.
REQ-029 Without RTC_TIMER_IRQ_EN: 0x41 and 0x0F SHALL be unmapped and IRQ SHALL be tied to 1.

Structure
REQ-030 A shared package/include SHALL hold the register address constants (0x21, 0x22, 0x23, 0x41, 0x0F) and the control bit indices, shared with the initiator-side port.
REQ-031 A single sub-module rtc_bcd_cnt (BCD increment, load, configurable max, carry out) SHALL be instantiated three times.

Verification
REQ-032 Address write 0x21, then data write 0x45, then read 0x21 -> bus = 0x45 within 3 clk of RD low; Z one clk after RD high.
REQ-033 TICK_DIV=4, time 23:59:59 -> after one tick, hours/min/sec = 0x00/0x00/0x00.
REQ-034 Write 0x3A to seconds, tick -> 0x40; write 0x7F, tick -> 0x00 and minutes +1.
REQ-035 With RTC_TIMER_IRQ_EN: IE=1, timer=0x02 -> IRQ low after 2 ticks with TF=1; write 0x02 to 0x0F -> IRQ high; timer stays 0x00.
REQ-036 Read of 0x10 -> 0x00; assert rst mid-read -> bus Z and all registers at REQ-024 values.

Source files
------------

// File: rtl/rtc_bus_responder_pkg.sv
// rtc_bus_responder_pkg: register map, control bit indices and BCD increment rule shared by responder and initiator
// Contents:
//   ADDR_SEC/ADDR_MIN/ADDR_HR/ADDR_TMR/ADDR_CTRL  register addresses
//   CTRL_TF/CTRL_IE                               control register bit indices
//   bcd_inc(v, max)                               next value of a BCD time field
package rtc_bus_responder_pkg;
    localparam logic [7:0] ADDR_SEC  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HR   = 8'h23;
    localparam logic [7:0] ADDR_TMR  = 8'h41;
    localparam logic [7:0] ADDR_CTRL = 8'h0F;
    localparam int CTRL_TF = 0;
    localparam int CTRL_IE = 1;
    // Anything at or past max (including invalid BCD) wraps to 0; a low nibble of 9 or more carries into the high nibble.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        return (v >= max) ? 8'h00 : (v[3:0] >= 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
    endfunction
endpackage

// File: rtl/rtc_bcd_cnt.sv
// rtc_bcd_cnt: loadable BCD time field with configurable wrap value and carry out
// Ports:
//   clk, rst   clock, asynchronous active-high reset (clears q)
//   inc        advance one step
//   load, din  load din; takes priority over inc and suppresses carry
//   q          current value
//   carry      high in the cycle the field wraps from max
module rtc_bcd_cnt
    import rtc_bus_responder_pkg::*;
#(
    parameter logic [7:0] MAX = 8'h59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] din,
    output logic [7:0] q,
    output logic       carry
);
    assign carry = inc & ~load & (q >= MAX);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 8'h00;
        else if (load) q <= din;
        else if (inc) q <= bcd_inc(q, MAX);
    end
endmodule

// File: rtl/rtc_bus_responder.sv
// rtc_bus_responder: real-time clock on a multiplexed 8-bit async bus
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   AD, CS, RD, WR      active-low bus controls (AD: 0 address phase, 1 data phase)
//   bus                 multiplexed address/data, driven only while reading
//   IRQ                 active-low interrupt request
// Parameter TICK_DIV: clk cycles per 1 Hz tick (min 4).
// Macro RTC_TIMER_IRQ_EN: enables countdown timer (0x41), control register (0x0F) and IRQ;
// without it those addresses are unmapped and IRQ stays high.
module rtc_bus_responder
    import rtc_bus_responder_pkg::*;
#(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       AD,
    input  logic       CS,
    input  logic       RD,
    input  logic       WR,
    inout  wire  [7:0] bus,
    output logic       IRQ
);
    localparam int PW = $clog2(TICK_DIV);
    logic [3:0] s1, s2;
    logic wr_d, drv_en, tick, wr_rise, we;
    logic [7:0] addr, cap, rd_data, sec, min, hr;
    logic [PW-1:0] pre;
    logic sec_ld, min_ld, hr_ld, sec_c, min_c, unused_hr_carry;
    wire s_ad = s2[3];
    wire s_cs = s2[2];
    wire s_rd = s2[1];
    wire s_wr = s2[0];
    assign wr_rise = s_wr & ~wr_d;
    assign we      = wr_rise & ~s_cs & s_ad;
    assign sec_ld  = we & (addr == ADDR_SEC);
    assign min_ld  = we & (addr == ADDR_MIN);
    assign hr_ld   = we & (addr == ADDR_HR);
    assign tick    = (pre == PW'(TICK_DIV - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '1;
            s2     <= '1;
            wr_d   <= 1'b1;
            drv_en <= 1'b0;
            addr   <= 8'h00;
            cap    <= 8'h00;
            pre    <= '0;
        end else begin
            s1     <= {AD, CS, RD, WR};
            s2     <= s1;
            wr_d   <= s_wr;
            drv_en <= ~s_cs & ~s_rd & s_ad;
            if (!s_wr) cap <= bus;
            if (wr_rise && !s_cs && !s_ad) addr <= cap;
            pre    <= (tick || sec_ld) ? '0 : pre + 1'b1;
        end
    end
    rtc_bcd_cnt #(.MAX(8'h59)) u_sec (
        .clk(clk), .rst(rst), .inc(tick), .load(sec_ld), .din(cap), .q(sec), .carry(sec_c)
    );
    rtc_bcd_cnt #(.MAX(8'h59)) u_min (
        .clk(clk), .rst(rst), .inc(sec_c), .load(min_ld), .din(cap), .q(min), .carry(min_c)
    );
    rtc_bcd_cnt #(.MAX(8'h23)) u_hr (
        .clk(clk), .rst(rst), .inc(min_c), .load(hr_ld), .din(cap), .q(hr), .carry(unused_hr_carry)
    );
`ifdef RTC_TIMER_IRQ_EN
    logic [7:0] tmr, ctrl;
    logic ie, tf, tmr_ld, ctrl_ld, tf_set;
    assign tmr_ld  = we & (addr == ADDR_TMR);
    assign ctrl_ld = we & (addr == ADDR_CTRL);
    // A timer load in the tick cycle wins, so no 1 -> 0 transition happens then.
    assign tf_set  = tick & ~tmr_ld & (tmr == 8'd1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= 8'h00;
            ie  <= 1'b0;
            tf  <= 1'b0;
        end else begin
            if (tmr_ld) tmr <= cap;
            else if (tick && tmr != 8'h00) tmr <= tmr - 8'd1;
            if (ctrl_ld) ie <= cap[CTRL_IE];
            // TF is write-0-to-clear; a set in the same cycle wins.
            tf <= tf_set | (tf & ~(ctrl_ld & ~cap[CTRL_TF]));
        end
    end
    always_comb begin
        ctrl = 8'h00;
        ctrl[CTRL_IE] = ie;
        ctrl[CTRL_TF] = tf;
    end
    assign IRQ = ~(tf & ie);
`else
    assign IRQ = 1'b1;
`endif
    always_comb begin
        rd_data = 8'h00;
        if (addr == ADDR_SEC) rd_data = sec;
        if (addr == ADDR_MIN) rd_data = min;
        if (addr == ADDR_HR) rd_data = hr;
`ifdef RTC_TIMER_IRQ_EN
        if (addr == ADDR_TMR) rd_data = tmr;
        if (addr == ADDR_CTRL) rd_data = ctrl;
`endif
    end
    assign bus = drv_en ? rd_data : 8'hzz;
endmodule

// File: tb/tb_rtc_bus_responder.sv
// tb_rtc_bus_responder: randomized self-checking bench with a tick-level time model
module tb_rtc_bus_responder;
    localparam int TD = 256;
    localparam logic [7:0] A_SEC = 8'h21, A_MIN = 8'h22, A_HR = 8'h23, A_TMR = 8'h41, A_CTRL = 8'h0F;
    logic clk = 1'b0, rst = 1'b1, ad = 1'b1, cs = 1'b1, rd = 1'b1, wr = 1'b1, bus_oe = 1'b0;
    logic [7:0] bus_drv = 8'h00;
    wire [7:0] bus;
    wire irq;
    int cyc = 0, checks = 0, failures = 0, t0 = 0;
    logic [7:0] m_s, m_m, m_h;

    assign bus = bus_oe ? bus_drv : 8'hzz;
    pullup (bus);

    rtc_bus_responder #(.TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .AD(ad), .CS(cs), .RD(rd), .WR(wr), .bus(bus), .IRQ(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] nxt(input logic [7:0] v, input logic [7:0] mx);
        int hi, lo;
        hi = int'(v) / 16;
        lo = int'(v) % 16;
        if (v >= mx) return 8'h00;
        if (lo >= 9) return 8'((hi + 1) * 16);
        return 8'(int'(v) + 1);
    endfunction

    task automatic model_tick();
        logic cs_, cm_;
        cs_ = (m_s >= 8'h59);
        m_s = nxt(m_s, 8'h59);
        if (cs_) begin
            cm_ = (m_m >= 8'h59);
            m_m = nxt(m_m, 8'h59);
            if (cm_) m_h = nxt(m_h, 8'h23);
        end
    endtask

    task automatic phase_write(input logic a, input logic [7:0] d);
        @(negedge clk);
        ad = a; cs = 1'b0; bus_drv = d; bus_oe = 1'b1; wr = 1'b0;
        repeat (3) @(negedge clk);
        wr = 1'b1;
        repeat (3) @(negedge clk);
        bus_oe = 1'b0;
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        phase_write(1'b0, a);
        phase_write(1'b1, d);
        @(negedge clk);
        cs = 1'b1; ad = 1'b1;
    endtask

    task automatic reg_read(input logic [7:0] a, output logic [7:0] d);
        phase_write(1'b0, a);
        @(negedge clk);
        ad = 1'b1; rd = 1'b0;
        repeat (3) @(negedge clk);
        d = bus;
        @(negedge clk);
        rd = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus !== 8'hFF) begin
            failures++;
            $display("FAIL release addr %h: bus=%h expected released (ff)", a, bus);
        end
        cs = 1'b1;
    endtask

    task automatic expect_reg(input string nm, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] got;
        reg_read(a, got);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s addr %h: got %h expected %h", nm, a, got, exp);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus !== 8'hFF || irq !== 1'b1) begin
            failures++;
            $display("FAIL reset_io: bus=%h irq=%b expected ff 1", bus, irq);
        end
        rst = 1'b0;
        expect_reg("reset_sec", A_SEC, 8'h00);
        expect_reg("reset_min", A_MIN, 8'h00);
        expect_reg("reset_hr", A_HR, 8'h00);
        expect_reg("reset_tmr", A_TMR, 8'h00);
        expect_reg("reset_ctrl", A_CTRL, 8'h00);
    endtask

    task automatic test_rw();
        reg_write(A_SEC, 8'h45);
        expect_reg("rw_sec", A_SEC, 8'h45);
    endtask

    task automatic test_unmapped();
        logic [7:0] a;
        reg_write(8'h10, 8'h5A);
        expect_reg("unmapped_10", 8'h10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            do a = 8'($urandom_range(0, 255));
            while (a == A_SEC || a == A_MIN || a == A_HR || a == A_TMR || a == A_CTRL);
            reg_write(a, 8'($urandom_range(1, 254)));
            expect_reg("unmapped_rand", a, 8'h00);
        end
    endtask

    // Seconds write clears the prescaler, so tick k lands near t0 + k*TD; reads sit mid-interval.
    task automatic run_time(input string nm, input logic [7:0] s, input logic [7:0] m,
                            input logic [7:0] h, input int n);
        reg_write(A_SEC, s);
        t0 = cyc;
        reg_write(A_MIN, m);
        reg_write(A_HR, h);
        m_s = s; m_m = m; m_h = h;
        for (int k = 0; k < n; k++) model_tick();
        wait_until(t0 + n * TD + TD / 2);
        expect_reg({nm, "_sec"}, A_SEC, m_s);
        expect_reg({nm, "_min"}, A_MIN, m_m);
        expect_reg({nm, "_hr"}, A_HR, m_h);
    endtask

    task automatic test_rollover();
        run_time("rollover", 8'h59, 8'h59, 8'h23, 1);
        checks++;
        if (m_s !== 8'h00 || m_m !== 8'h00 || m_h !== 8'h00) begin
            failures++;
            $display("FAIL rollover_model: got %h:%h:%h expected 00:00:00", m_h, m_m, m_s);
        end
    endtask

    task automatic test_invalid_bcd();
        run_time("bcd_3a", 8'h3A, 8'h10, 8'h05, 1);
        run_time("bcd_7f", 8'h7F, 8'h10, 8'h05, 1);
    endtask

    task automatic test_random_time();
        for (int i = 0; i < 6; i++)
            run_time("rand", 8'($urandom_range(0, 5) * 16 + $urandom_range(0, 9)),
                     8'($urandom_range(0, 5) * 16 + $urandom_range(0, 9)),
                     8'($urandom_range(0, 23) / 10 * 16 + $urandom_range(0, 23) % 10 % 4),
                     $urandom_range(0, 3));
    endtask

    task automatic check_irq(input string nm, input logic exp);
        checks++;
        if (irq !== exp) begin
            failures++;
            $display("FAIL %s: irq=%b expected %b", nm, irq, exp);
        end
    endtask

`ifdef RTC_TIMER_IRQ_EN
    task automatic test_timer();
        reg_write(A_SEC, 8'h00);
        t0 = cyc;
        reg_write(A_CTRL, 8'h02);
        reg_write(A_TMR, 8'h02);
        wait_until(t0 + TD + TD / 2);
        check_irq("irq_after_1_tick", 1'b1);
        expect_reg("tmr_1", A_TMR, 8'h01);
        wait_until(t0 + 2 * TD + TD / 2);
        check_irq("irq_after_2_ticks", 1'b0);
        expect_reg("ctrl_tf", A_CTRL, 8'h03);
        expect_reg("tmr_0", A_TMR, 8'h00);
        reg_write(A_CTRL, 8'h02);
        check_irq("irq_cleared", 1'b1);
        expect_reg("ctrl_clr", A_CTRL, 8'h02);
        reg_write(A_CTRL, 8'h03);
        expect_reg("ctrl_w1", A_CTRL, 8'h02);
        wait_until(t0 + 3 * TD + TD / 2);
        expect_reg("tmr_stays_0", A_TMR, 8'h00);
        check_irq("irq_stays_high", 1'b1);
    endtask
`else
    task automatic test_timer();
        reg_write(A_TMR, 8'h55);
        reg_write(A_CTRL, 8'h03);
        expect_reg("no_tmr", A_TMR, 8'h00);
        expect_reg("no_ctrl", A_CTRL, 8'h00);
        check_irq("irq_tied", 1'b1);
    endtask
`endif

    task automatic test_reset_mid_read();
        reg_write(A_MIN, 8'h12);
        reg_write(A_HR, 8'h05);
        reg_write(A_TMR, 8'h40);
        reg_write(A_CTRL, 8'h02);
        reg_write(A_SEC, 8'h33);
        phase_write(1'b0, A_SEC);
        @(negedge clk);
        ad = 1'b1; rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus !== 8'h33) begin
            failures++;
            $display("FAIL midread_drive: bus=%h expected 33", bus);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus !== 8'hFF || irq !== 1'b1) begin
            failures++;
            $display("FAIL midread_abort: bus=%h irq=%b expected ff 1", bus, irq);
        end
        @(negedge clk);
        cs = 1'b1; rd = 1'b1; ad = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_reg("post_rst_sec", A_SEC, 8'h00);
        expect_reg("post_rst_min", A_MIN, 8'h00);
        expect_reg("post_rst_hr", A_HR, 8'h00);
        expect_reg("post_rst_tmr", A_TMR, 8'h00);
        expect_reg("post_rst_ctrl", A_CTRL, 8'h00);
    endtask

    initial begin
        test_reset();
        test_rw();
        test_unmapped();
        test_rollover();
        test_invalid_bcd();
        test_random_time();
        test_timer();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
